// File: rtl/seq_detect_ctrl.sv
// rtl/seq_detect_ctrl.sv - run-controlled programmable serial pattern detector
// Words are serialized MSB-first into a history register and matched against a latched pattern.
module seq_detect_ctrl #(
  parameter int WORD_W  = 8,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_load,
  input  logic               start,
  input  logic               stop,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  output logic               det_pulse,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err,
  output logic               busy
);

  localparam int BI_W = $clog2(WORD_W);
  localparam int VC_W = $clog2(MAX_LEN + 1);
  localparam logic [MAX_LEN-1:0] PAT_RST = MAX_LEN'(4'b1101);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(4);
  localparam logic [VC_W-1:0]    VC_MAX  = VC_W'(MAX_LEN);
  localparam logic [BI_W-1:0]    BI_LAST = BI_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_SHIFT} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [VC_W-1:0]    vcnt_q, vcnt_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [BI_W-1:0]    bidx_q, bidx_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               det_q, det_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] hist_shift;
  logic [VC_W-1:0]    vcnt_inc;
  logic               match;
  logic               last_bit;
  logic               stop_eff;
  logic               accept;
  logic               cfg_ok;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (i < int'(len_q));
    end
  end

  // The shifted-in bit and its saturated count decide the match for this cycle.
  assign hist_shift = MAX_LEN'({hist_q, word_q[WORD_W-1]});
  assign vcnt_inc   = (vcnt_q == VC_MAX) ? vcnt_q : vcnt_q + VC_W'(1);
  assign match      = (state_q == ST_SHIFT)
                   && ((hist_shift & mask) == (pat_q & mask))
                   && (int'(vcnt_inc) >= int'(len_q));
  assign last_bit   = (bidx_q == BI_LAST);
  assign stop_eff   = stop | pend_q;
  assign accept     = s_valid & s_ready;
  assign cfg_ok     = (cfg_len != '0) && (int'(cfg_len) <= MAX_LEN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= PAT_RST;
      len_q   <= LEN_RST;
      ovl_q   <= 1'b1;
      hist_q  <= '0;
      vcnt_q  <= '0;
      word_q  <= '0;
      bidx_q  <= '0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      hist_q  <= hist_d;
      vcnt_q  <= vcnt_d;
      word_q  <= word_d;
      bidx_q  <= bidx_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      det_q   <= det_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop)         state_d = ST_IDLE;
        else if (s_valid) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_bit) begin
          if (stop_eff)    state_d = ST_IDLE;
          else if (accept) state_d = ST_SHIFT;
          else             state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    case (state_q)
      ST_WAIT:  s_ready = !stop;
      ST_SHIFT: s_ready = last_bit && !stop_eff;
      default:  s_ready = 1'b0;
    endcase
    busy        = (state_q != ST_IDLE);
    det_pulse   = det_q;
    match_count = cnt_q;
    cfg_err     = err_q;
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    hist_d = hist_q;
    vcnt_d = vcnt_q;
    word_d = word_q;
    bidx_d = bidx_q;
    pend_d = pend_q;
    cnt_d  = cnt_q;
    det_d  = 1'b0;
    err_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Load is evaluated before start so a combined pulse runs with the new config.
        if (cfg_load) begin
          if (cfg_ok) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
          end else begin
            err_d = 1'b1;
          end
        end
        if (start) begin
          hist_d = '0;
          vcnt_d = '0;
          cnt_d  = '0;
          pend_d = 1'b0;
        end
      end
      ST_WAIT: begin
        if (accept) begin
          word_d = s_data;
          bidx_d = '0;
        end
      end
      ST_SHIFT: begin
        hist_d = hist_shift;
        vcnt_d = (match && !ovl_q) ? '0 : vcnt_inc;
        word_d = {word_q[WORD_W-2:0], 1'b0};
        bidx_d = bidx_q + BI_W'(1);
        det_d  = match;
        if (match && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
        if (stop) pend_d = 1'b1;
        if (last_bit) begin
          pend_d = 1'b0;
          if (accept) begin
            word_d = s_data;
            bidx_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
